// File: rtl/win_banner_controller_if.sv
// Signal bundle between the win banner controller and the VGA, game-state and text-map blocks.
// The slave modport is the controller's view; master is the driving side.
interface win_banner_controller_if;
    logic       frame_tick;
    logic       win_event;
    logic       start_key;
    logic [9:0] DrawX;
    logic [9:0] DrawY;
    logic       map_pixel;
    logic [5:0] map_x;
    logic [4:0] map_y;
    logic       text_on;
    logic       banner_active;
    logic       restart;

    modport slave (
        input  frame_tick, win_event, start_key, DrawX, DrawY, map_pixel,
        output map_x, map_y, text_on, banner_active, restart
    );

    modport master (
        output frame_tick, win_event, start_key, DrawX, DrawY, map_pixel,
        input  map_x, map_y, text_on, banner_active, restart
    );
endinterface

// File: rtl/win_banner_controller.sv
// "YOU WIN" banner sequencer (blink, hold, wait for start key, restart) plus VGA-to-text-map mapping.
// Pixel path latency 2 cycles (DrawX/Y -> map_x/y -> text_on); no backpressure, inputs sampled every cycle.
module win_banner_controller #(
    parameter int ORIGIN_X      = 272,
    parameter int ORIGIN_Y      = 176,
    parameter int SCALE_LOG2    = 2,
    parameter int BLINK_FRAMES  = 15,
    parameter int BLINK_TOGGLES = 6,
    parameter int HOLD_FRAMES   = 120
) (
    input  logic                    Clk,
    input  logic                    Reset_n,
    win_banner_controller_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_BLINK,
        S_HOLD,
        S_WAIT_KEY,
        S_RESTART
    } state_t;

    localparam logic [9:0] BOX_W      = 10'(24 << SCALE_LOG2);
    localparam logic [9:0] BOX_H      = 10'(32 << SCALE_LOG2);
    localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES - 1);
    localparam logic [7:0] HOLD_LAST  = 8'(HOLD_FRAMES - 1);
    localparam logic [7:0] TOGGLE_END = 8'(BLINK_TOGGLES);

    state_t     r_state;
    logic [7:0] r_frame_cnt;
    logic [7:0] r_toggle_cnt;
    logic       r_visible;
    logic       r_key_prev;
    logic       r_banner_active;
    logic       r_restart;
    logic [5:0] r_map_x;
    logic [4:0] r_map_y;
    logic       r_in_box_d;
    logic       r_text_on;

    state_t     w_state_nxt;
    logic [7:0] w_frame_nxt;
    logic [7:0] w_toggle_nxt;
    logic       w_visible_nxt;
    logic       w_key_rise;
    logic [9:0] w_dx;
    logic [9:0] w_dy;
    logic       w_in_box;

    assign w_key_rise = bus.start_key & ~r_key_prev;

    always_comb begin
        w_state_nxt   = r_state;
        w_frame_nxt   = r_frame_cnt;
        w_toggle_nxt  = r_toggle_cnt;
        w_visible_nxt = r_visible;
        case (r_state)
            S_IDLE: begin
                if (bus.win_event) begin
                    w_state_nxt   = S_BLINK;
                    w_frame_nxt   = '0;
                    w_toggle_nxt  = '0;
                    w_visible_nxt = 1'b1;
                end
            end
            S_BLINK: begin
                if (bus.frame_tick) begin
                    if (r_frame_cnt == BLINK_LAST) begin
                        w_frame_nxt   = '0;
                        w_visible_nxt = ~r_visible;
                        w_toggle_nxt  = r_toggle_cnt + 8'd1;
                        // Even toggle count guarantees visible is back to 1 here
                        if (w_toggle_nxt == TOGGLE_END) begin
                            w_state_nxt = S_HOLD;
                        end
                    end else begin
                        w_frame_nxt = r_frame_cnt + 8'd1;
                    end
                end
            end
            S_HOLD: begin
                w_visible_nxt = 1'b1;
                if (bus.frame_tick) begin
                    if (r_frame_cnt == HOLD_LAST) begin
                        w_state_nxt = S_WAIT_KEY;
                        w_frame_nxt = '0;
                    end else begin
                        w_frame_nxt = r_frame_cnt + 8'd1;
                    end
                end
            end
            S_WAIT_KEY: begin
                w_visible_nxt = 1'b1;
                if (w_key_rise) begin
                    w_state_nxt = S_RESTART;
                end
            end
            S_RESTART: begin
                w_state_nxt   = S_IDLE;
                w_visible_nxt = 1'b0;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Left/above-origin pixels wrap to large values and drop out of the box
    assign w_dx     = bus.DrawX - 10'(ORIGIN_X);
    assign w_dy     = bus.DrawY - 10'(ORIGIN_Y);
    assign w_in_box = (w_dx < BOX_W) && (w_dy < BOX_H);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state         <= S_IDLE;
            r_frame_cnt     <= '0;
            r_toggle_cnt    <= '0;
            r_visible       <= 1'b0;
            r_key_prev      <= 1'b1;
            r_banner_active <= 1'b0;
            r_restart       <= 1'b0;
            r_map_x         <= '0;
            r_map_y         <= '0;
            r_in_box_d      <= 1'b0;
            r_text_on       <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_frame_cnt     <= w_frame_nxt;
            r_toggle_cnt    <= w_toggle_nxt;
            r_visible       <= w_visible_nxt;
            r_key_prev      <= bus.start_key;
            r_banner_active <= (w_state_nxt != S_IDLE);
            r_restart       <= (w_state_nxt == S_RESTART);
            r_map_x         <= w_in_box ? 6'(w_dx >> SCALE_LOG2) : 6'd0;
            r_map_y         <= w_in_box ? 5'(w_dy >> SCALE_LOG2) : 5'd0;
            r_in_box_d      <= w_in_box;
            r_text_on       <= r_in_box_d & bus.map_pixel & r_visible & r_banner_active;
        end
    end

    assign bus.map_x         = r_map_x;
    assign bus.map_y         = r_map_y;
    assign bus.text_on       = r_text_on;
    assign bus.banner_active = r_banner_active;
    assign bus.restart       = r_restart;

endmodule

// File: tb/tb_win_banner_controller.sv
// Bench for win_banner_controller: mapping vectors, blink/hold/restart sequences, async reset, randomized mapping.
module tb_win_banner_controller;
    localparam int BF = 2;
    localparam int BT = 4;
    localparam int HF = 3;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    win_banner_controller_if bus();

    win_banner_controller #(
        .ORIGIN_X(272), .ORIGIN_Y(176), .SCALE_LOG2(2),
        .BLINK_FRAMES(BF), .BLINK_TOGGLES(BT), .HOLD_FRAMES(HF)
    ) dut (
        .Clk(clk),
        .Reset_n(rst_n),
        .bus(bus)
    );

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [9:0] x;
        logic [9:0] y;
        logic [5:0] mx;
        logic [4:0] my;
        logic       on;
    } vec_t;
    vec_t tbl[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic tick();
        bus.frame_tick = 1'b1;
        cyc(1);
        bus.frame_tick = 1'b0;
        cyc(1);
    endtask

    task automatic win_pulse();
        bus.win_event = 1'b1;
        cyc(1);
        bus.win_event = 1'b0;
    endtask

    // Reference model: plain modular arithmetic on screen coordinates
    function automatic int m_rx(input logic [9:0] x);
        return (int'(x) - 272 + 1024) % 1024;
    endfunction
    function automatic int m_ry(input logic [9:0] y);
        return (int'(y) - 176 + 1024) % 1024;
    endfunction
    function automatic bit m_inbox(input logic [9:0] x, input logic [9:0] y);
        return (m_rx(x) < 24 * 4) && (m_ry(y) < 32 * 4);
    endfunction
    function automatic int m_mx(input logic [9:0] x, input logic [9:0] y);
        return m_inbox(x, y) ? (m_rx(x) / 4) % 64 : 0;
    endfunction
    function automatic int m_my(input logic [9:0] x, input logic [9:0] y);
        return m_inbox(x, y) ? (m_ry(y) / 4) % 32 : 0;
    endfunction
    // Visibility during blink frame f counted from entry
    function automatic bit m_vis(input int f);
        return ((f / BF) % 2) == 0;
    endfunction

    function automatic logic [9:0] rnd_coord(input bit is_x);
        if ($urandom_range(0, 1) == 0)
            return 10'($urandom_range(0, 1023));
        else if (is_x)
            return 10'($urandom_range(250, 400));
        else
            return 10'($urandom_range(150, 330));
    endfunction

    task automatic rand_map(input int n, input bit act, input string tag);
        logic [9:0] x0, y0, x1, y1;
        logic       mp0;
        x0 = rnd_coord(1'b1);
        y0 = rnd_coord(1'b0);
        bus.DrawX = x0;
        bus.DrawY = y0;
        bus.map_pixel = 1'($urandom_range(0, 1));
        cyc(1);
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_map_x", tag), 32'(bus.map_x), 32'(m_mx(x0, y0)));
            chk($sformatf("%s_map_y", tag), 32'(bus.map_y), 32'(m_my(x0, y0)));
            x1 = x0;
            y1 = y0;
            x0 = rnd_coord(1'b1);
            y0 = rnd_coord(1'b0);
            mp0 = 1'($urandom_range(0, 1));
            bus.DrawX = x0;
            bus.DrawY = y0;
            bus.map_pixel = mp0;
            cyc(1);
            chk($sformatf("%s_text_on", tag), 32'(bus.text_on), 32'(m_inbox(x1, y1) & mp0 & act));
        end
    endtask

    initial begin
        int f;

        tbl[0] = '{10'd272, 10'd176, 6'd0,  5'd0,  1'b1};
        tbl[1] = '{10'd367, 10'd303, 6'd23, 5'd31, 1'b1};
        tbl[2] = '{10'd368, 10'd200, 6'd0,  5'd0,  1'b0};
        tbl[3] = '{10'd271, 10'd200, 6'd0,  5'd0,  1'b0};
        tbl[4] = '{10'd300, 10'd190, 6'd7,  5'd3,  1'b1};
        tbl[5] = '{10'd300, 10'd304, 6'd0,  5'd0,  1'b0};
        tbl[6] = '{10'd300, 10'd175, 6'd0,  5'd0,  1'b0};
        tbl[7] = '{10'd0,   10'd0,   6'd0,  5'd0,  1'b0};

        // Reset with key held and pixel inside the box
        rst_n = 1'b0;
        bus.frame_tick = 1'b0;
        bus.win_event = 1'b0;
        bus.start_key = 1'b1;
        bus.DrawX = 10'd280;
        bus.DrawY = 10'd180;
        bus.map_pixel = 1'b1;
        cyc(3);
        chk("rst_map_x", 32'(bus.map_x), 32'd0);
        chk("rst_text_on", 32'(bus.text_on), 32'd0);
        chk("rst_active", 32'(bus.banner_active), 32'd0);
        chk("rst_restart", 32'(bus.restart), 32'd0);
        rst_n = 1'b1;
        cyc(3);
        chk("idle_map_x", 32'(bus.map_x), 32'd2);
        chk("idle_map_y", 32'(bus.map_y), 32'd1);
        chk("idle_text_on", 32'(bus.text_on), 32'd0);
        chk("idle_active", 32'(bus.banner_active), 32'd0);
        bus.start_key = 1'b0;

        // Blink schedule; the win cycle also carries a tick that must not count
        bus.win_event = 1'b1;
        bus.frame_tick = 1'b1;
        cyc(1);
        bus.win_event = 1'b0;
        bus.frame_tick = 1'b0;
        chk("win_active", 32'(bus.banner_active), 32'd1);
        cyc(2);
        f = 0;
        for (int k = 0; k < BF * BT; k++) begin
            chk($sformatf("blink_vis_f%0d", f), 32'(bus.text_on), 32'(m_vis(f)));
            if (k == 2) begin
                bus.start_key = 1'b1;
                cyc(1);
                chk("blink_key_restart", 32'(bus.restart), 32'd0);
                bus.start_key = 1'b0;
                cyc(1);
            end
            tick();
            f++;
        end
        cyc(2);
        chk("hold_vis", 32'(bus.text_on), 32'd1);
        chk("hold_active", 32'(bus.banner_active), 32'd1);

        // Hold: a second win_event must not disturb the count
        tick();
        win_pulse();
        cyc(1);
        tick();
        chk("hold_vis2", 32'(bus.text_on), 32'd1);
        bus.start_key = 1'b1;
        cyc(1);
        chk("hold_key_restart_a", 32'(bus.restart), 32'd0);
        cyc(1);
        chk("hold_key_restart_b", 32'(bus.restart), 32'd0);
        bus.start_key = 1'b0;
        cyc(1);
        bus.start_key = 1'b1;
        cyc(1);
        tick();
        for (int k = 0; k < 3; k++) begin
            cyc(1);
            chk("wait_held_key_restart", 32'(bus.restart), 32'd0);
        end
        chk("wait_active", 32'(bus.banner_active), 32'd1);

        // Mapping vectors in WAIT_KEY with map_pixel tied high
        bus.map_pixel = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.DrawX = tbl[i].x;
            bus.DrawY = tbl[i].y;
            cyc(1);
            chk($sformatf("tbl%0d_map_x", i), 32'(bus.map_x), 32'(tbl[i].mx));
            chk($sformatf("tbl%0d_map_y", i), 32'(bus.map_y), 32'(tbl[i].my));
            cyc(1);
            chk($sformatf("tbl%0d_text_on", i), 32'(bus.text_on), 32'(tbl[i].on));
        end

        // Latency: step into the box, text_on follows two cycles later
        bus.DrawX = 10'd271;
        bus.DrawY = 10'd200;
        cyc(3);
        chk("lat_before", 32'(bus.text_on), 32'd0);
        bus.DrawX = 10'd272;
        cyc(1);
        chk("lat_t1", 32'(bus.text_on), 32'd0);
        cyc(1);
        chk("lat_t2", 32'(bus.text_on), 32'd1);

        rand_map(200, 1'b1, "rnd_wait");
        chk("rnd_wait_restart", 32'(bus.restart), 32'd0);

        // Restart handshake
        bus.start_key = 1'b0;
        cyc(1);
        bus.start_key = 1'b1;
        cyc(1);
        chk("restart_pulse", 32'(bus.restart), 32'd1);
        chk("restart_active", 32'(bus.banner_active), 32'd1);
        cyc(1);
        chk("restart_done", 32'(bus.restart), 32'd0);
        chk("restart_idle", 32'(bus.banner_active), 32'd0);
        bus.start_key = 1'b0;

        rand_map(150, 1'b0, "rnd_idle");

        // Async reset during BLINK while the banner is drawn
        bus.DrawX = 10'd280;
        bus.DrawY = 10'd180;
        bus.map_pixel = 1'b1;
        win_pulse();
        cyc(3);
        chk("pre_reset_text_on", 32'(bus.text_on), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_text_on", 32'(bus.text_on), 32'd0);
        chk("async_active", 32'(bus.banner_active), 32'd0);
        chk("async_map_x", 32'(bus.map_x), 32'd0);
        chk("async_map_y", 32'(bus.map_y), 32'd0);
        chk("async_restart", 32'(bus.restart), 32'd0);
        cyc(2);
        rst_n = 1'b1;
        cyc(2);
        win_pulse();
        cyc(2);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("post_reset_vis_f%0d", k), 32'(bus.text_on), 32'(m_vis(k)));
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL timeout actual=running expected=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/win_banner_controller.md
# win_banner_controller

Sequences the end-of-game "YOU WIN" banner overlay. On a win event it runs a blink-then-hold display schedule, then waits for the player's start key and issues a one-cycle restart request. It maps VGA scan coordinates onto the 24x32 two-row text-map coordinate space with integer upscaling and drives the text map's X/Y inputs. It sits between the VGA controller, the game-state logic and the you-win text map, and feeds a registered `text_on` into the colour mapper.

## Interface
- ORIGIN_X, 272: screen X of the banner's top-left pixel.
- ORIGIN_Y, 176: screen Y of the banner's top-left pixel.
- SCALE_LOG2, 2: banner scale. Each text-map pixel is a (1<<SCALE_LOG2)-pixel square; range 0..3.
- BLINK_FRAMES, 15: frames per blink half-period; range 1..255.
- BLINK_TOGGLES, 6: visibility toggles in BLINK; must be even, range 2..254.
- HOLD_FRAMES, 120: frames the banner is held solid after blinking; range 1..255.
- Clk  in  1  system/pixel clock.
- Reset_n  in  1  reset, asynchronous, active-low.
- frame_tick  in  1  one-cycle pulse per frame (from VGA controller).
- win_event  in  1  one-cycle pulse when the last alien is destroyed.
- start_key  in  1  level, high while start key pressed.
- DrawX  in  10  current scan X.
- DrawY  in  10  current scan Y.
- map_pixel  in  1  text-map pixel for current map_x/map_y (combinational return).
- map_x  out  6  text-map X, 0..23.
- map_y  out  5  text-map Y, 0..31.
- text_on  out  1  draw banner foreground at this pixel.
- banner_active  out  1  high in any state except IDLE.
- restart  out  1  one-cycle game restart request.

## Operation
- States: IDLE, BLINK, HOLD, WAIT_KEY, RESTART.
- IDLE: `win_event` -> BLINK with frame_cnt=0, toggle_cnt=0, visible=1.
- Outside IDLE, `win_event` is ignored.
- BLINK: on each `frame_tick`, frame_cnt increments. At frame_cnt==BLINK_FRAMES-1 the following happen together: frame_cnt clears, visible inverts, toggle_cnt increments.
- BLINK exit: when the increment brings toggle_cnt to BLINK_TOGGLES -> HOLD with frame_cnt=0. visible is 1 at this point because the toggle count is even.
- HOLD: visible=1. Count `frame_tick`s; at frame_cnt==HOLD_FRAMES-1 -> WAIT_KEY.
- WAIT_KEY: visible=1. A rising edge of `start_key` -> RESTART. Edge detection uses a key_prev register with reset value 1, so a key held through reset does not fire.
- `start_key` edges in IDLE, BLINK and HOLD are ignored. key_prev still tracks the key in those states.
- RESTART: `restart`=1 for exactly one cycle, then -> IDLE.
- Counters are 8 bits wide and never wrap in a legal configuration.
- Coordinate mapping: dx = DrawX - ORIGIN_X and dy = DrawY - ORIGIN_Y, both 10-bit modular.
- in_box = (dx < 24<<SCALE_LOG2) && (dy < 32<<SCALE_LOG2), unsigned compare. Pixels left of or above the origin wrap to large values and fail the compare.
- map_x = dx >> SCALE_LOG2 and map_y = dy >> SCALE_LOG2, truncated to 6/5 bits.
- Outside the box, map_x=0 and map_y=0.
- text_on = in_box_d & map_pixel & visible & banner_active.

## Timing
- Pipeline stage 1: DrawX/DrawY at cycle t -> registered map_x, map_y, in_box_d at t+1.
- `map_pixel` returns combinationally in cycle t+1.
- Pipeline stage 2: registered `text_on` at t+2. Total latency is 2 cycles; the colour mapper delays its other layers to match.
- State and visible update on the edge after the triggering input.
- `banner_active` is registered from state and rises one cycle after `win_event`.
- `restart` asserts the cycle after the sampled key edge.
- Same-cycle `win_event` and `frame_tick` in IDLE: enter BLINK; that tick is not counted.
- Reset values: state=IDLE; map_x=0, map_y=0, text_on=0, banner_active=0, restart=0; counters 0; visible=0; key_prev=1.
- `Reset_n` low mid-sequence returns the block to IDLE immediately, asynchronously, with all outputs 0.

## Test plan
- Mapping: defaults, banner_active forced via win_event.
  - DrawX=272, DrawY=176 -> map_x=0, map_y=0, in_box after 1 cycle.
  - DrawX=367, DrawY=303 -> map_x=23, map_y=31.
  - DrawX=368 or DrawX=271 -> text_on=0 regardless of map_pixel.
- Latency: map_pixel tied 1 in HOLD, DrawX steps into the box at cycle t -> text_on rises at t+2.
- Blink schedule with BLINK_FRAMES=2, BLINK_TOGGLES=4, HOLD_FRAMES=3:
  - visible pattern per frame_tick is 1,1,0,0,1,1,0,0.
  - Enter HOLD, then WAIT_KEY after 3 further ticks.
- Restart handshake:
  - start_key held high entering WAIT_KEY -> no restart.
  - Release, then press -> restart=1 for exactly 1 cycle, then banner_active=0.
- Ignored events:
  - Second win_event during HOLD -> counters unaffected.
  - start_key edge during BLINK -> no restart.
  - Same-cycle win_event + frame_tick in IDLE -> frame_cnt=0 in BLINK.
- Reset: assert Reset_n=0 during BLINK with text_on=1 -> all outputs 0 without waiting for Clk. After release, win_event restarts the schedule from frame 0.
